spi_txn_arbiter: RTL and testbench

Shares one byte-wide spi_master between two requesters and sequences multi-byte transactions over it. Per transaction: round-robin arbitration, drive active-low chip select with programmable setup/hold guard time, then feed bytes through the master's start_transfer/done handshake. Sits between client logic (sensor poller, config writer) and spi_master.

---
 rtl/spi_txn_arbiter_pkg.sv | 23 ++
 rtl/spi_txn_arbiter_rr_arbiter2.sv | 32 +++
 rtl/spi_txn_arbiter.sv | 137 +++++++++++++
 tb/tb_spi_txn_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// Shared definitions for the two-requester SPI transaction arbiter:
// requester/byte sizing, sequencer state encoding and a one-hot helper.
package spi_txn_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        WAIT_DONE,
        WAIT_REL,
        GAP,
        CS_HOLD,
        FINISH
    } state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the favoured requester,
// and after each accepted grant it moves to the requester that lost.
module rr_arbiter2
    import spi_txn_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_idx
);

    logic r_ptr;

    always_comb begin
        o_idx = i_req[1];
        if (i_req == 2'b11) begin
            o_idx = r_ptr;
        end
        o_gnt = (i_req == 2'b00) ? 2'b00 : req_onehot(o_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (i_req != 2'b00)) begin
            r_ptr <= ~o_idx;
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one byte-wide spi_master between two requesters: arbitrates per
// transaction, frames it with cs_n setup/hold guard time and paces bytes.
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int LEN_W      = 4,
    parameter int CS_DELAY   = 16,
    parameter int GAP_CYCLES = 4
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*BYTE_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        byte_ack,
    output logic [BYTE_W-1:0]         rx_data,
    output logic [NUM_REQ-1:0]        rx_valid,
    output logic [NUM_REQ-1:0]        txn_done,
    output logic                      cs_n,
    output logic [BYTE_W-1:0]         spi_tx_data,
    output logic                      spi_start,
    input  logic [BYTE_W-1:0]         spi_rx_data,
    input  logic                      spi_done
);

    localparam int TMR_MAX = (CS_DELAY > GAP_CYCLES) ? CS_DELAY : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] CS_END  = TMR_W'(CS_DELAY - 1);
    localparam logic [TMR_W-1:0] GAP_END = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner;
    logic [LEN_W-1:0]     r_cnt;
    logic [TMR_W-1:0]     r_tmr;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_cs_n;
    logic                 r_spi_start;
    logic [BYTE_W-1:0]    r_spi_tx;
    logic [BYTE_W-1:0]    r_rx_data;
    logic [NUM_REQ-1:0]   r_rx_valid;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic                 w_arb_idx;
    logic                 w_any;
    logic [LEN_W-1:0]     w_sel_len;
    logic                 w_owner_nx;
    logic                 w_byte_in;
    logic [NUM_REQ-1:0]   w_own_oh;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_advance (r_state == IDLE),
        .o_gnt     (w_arb_gnt),
        .o_idx     (w_arb_idx)
    );

    assign w_any      = (w_arb_gnt != 2'b00);
    assign w_sel_len  = w_arb_idx ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    assign w_owner_nx = (r_state == IDLE) ? w_arb_idx : r_owner;
    assign w_byte_in  = (r_state == WAIT_DONE) && spi_done;
    assign w_own_oh   = req_onehot(r_owner);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (w_any) w_next = (w_sel_len == '0) ? FINISH : CS_SETUP;
            CS_SETUP:  if (r_tmr == CS_END) w_next = LOAD;
            LOAD:      w_next = WAIT_DONE;
            WAIT_DONE: if (spi_done) w_next = WAIT_REL;
            WAIT_REL: begin
                if (!spi_done) begin
                    if (r_cnt == '0)          w_next = CS_HOLD;
                    else if (GAP_CYCLES == 0) w_next = LOAD;
                    else                      w_next = GAP;
                end
            end
            GAP:       if (r_tmr == GAP_END) w_next = LOAD;
            CS_HOLD:   if (r_tmr == CS_END) w_next = FINISH;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Outputs that must be glitch-free are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_grant     <= '0;
            r_cs_n      <= 1'b1;
            r_spi_start <= 1'b0;
            r_spi_tx    <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_tmr <= '0;
            end else if (r_state inside {CS_SETUP, GAP, CS_HOLD}) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (r_state == IDLE && w_any) begin
                r_owner <= w_arb_idx;
                r_cnt   <= w_sel_len;
            end else if (w_byte_in) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_grant     <= (w_next == IDLE) ? 2'b00 : req_onehot(w_owner_nx);
            r_cs_n      <= !(w_next inside {CS_SETUP, LOAD, WAIT_DONE, WAIT_REL, GAP, CS_HOLD});
            r_spi_start <= (w_next == WAIT_DONE);
            if (r_state == LOAD) begin
                r_spi_tx <= r_owner ? tx_data[2*BYTE_W-1:BYTE_W] : tx_data[BYTE_W-1:0];
            end
            if (w_byte_in) begin
                r_rx_data <= spi_rx_data;
            end
            r_rx_valid <= w_byte_in ? w_own_oh : 2'b00;
        end
    end

    assign grant       = r_grant;
    assign cs_n        = r_cs_n;
    assign spi_start   = r_spi_start;
    assign spi_tx_data = r_spi_tx;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign byte_ack    = (r_state == LOAD)   ? w_own_oh : 2'b00;
    assign txn_done    = (r_state == FINISH) ? w_own_oh : 2'b00;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a loopback spi_master model whose
// done latency and done width are adjustable per step.
module tb_spi_txn_arbiter;

    localparam int CSD = 16;
    localparam int GAPC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  req_len = 8'h00;
    logic [15:0] tx_data;
    logic [1:0]  grant, byte_ack, rx_valid, txn_done;
    logic [7:0]  rx_data, spi_tx_data;
    logic        cs_n, spi_start;
    logic [7:0]  spi_rx_data = 8'h00;
    logic        spi_done = 1'b0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.LEN_W(4), .CS_DELAY(CSD), .GAP_CYCLES(GAPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .tx_data     (tx_data),
        .grant       (grant),
        .byte_ack    (byte_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .txn_done    (txn_done),
        .cs_n        (cs_n),
        .spi_tx_data (spi_tx_data),
        .spi_start   (spi_start),
        .spi_rx_data (spi_rx_data),
        .spi_done    (spi_done)
    );

    int checks = 0;
    int failures = 0;

    // Byte sources per requester; the index advances one cycle after byte_ack.
    logic [7:0] tab0 [0:3];
    logic [7:0] tab1 [0:3];
    int base0 = 0, base1 = 0, txi0 = 0, txi1 = 0;
    assign tx_data = {tab1[2'(txi1 - base1)], tab0[2'(txi0 - base0)]};

    // Loopback master: done rises lat cycles after start, stays high hold cycles.
    int lat = 3, hold = 1, m_st = 0, m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_st = 0;
            spi_done = 1'b0;
        end else begin
            case (m_st)
                0: if (spi_start) begin m_byte = spi_tx_data; m_cnt = lat; m_st = 1; end
                1: begin
                    if (!spi_start) m_st = 0;
                    else begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            spi_done = 1'b1; spi_rx_data = m_byte; m_cnt = hold; m_st = 2;
                        end
                    end
                end
                2: begin
                    m_cnt--;
                    if (m_cnt == 0) begin spi_done = 1'b0; m_st = 3; end
                end
                default: if (!spi_start) m_st = 0;
            endcase
        end
    end

    // Event monitor sampled on the falling edge.
    int cyc = 0, ack0 = 0, ack1 = 0, done0 = 0, done1 = 0, rxv0 = 0, rxv1 = 0, rxn = 0;
    int t_cs_fall = 0, setup_c = 0, t_done_fall = 0, hold_c = 0, t_rise = 0, period = 0;
    int run = 0, hi_last = 0, start_rises = 0, cs_falls = 0, g_hi = 0, gn = 0;
    logic armed = 1'b0, pend0 = 1'b0, pend1 = 1'b0;
    logic p_cs = 1'b1, p_start = 1'b0, p_done = 1'b0;
    logic [1:0] p_grant = 2'b00;
    logic [7:0] rx_log [0:31];
    logic [1:0] g_log [0:15];

    always @(negedge clk) begin
        cyc++;
        if (pend0) txi0++;
        if (pend1) txi1++;
        pend0 = byte_ack[0];
        pend1 = byte_ack[1];
        if (byte_ack[0]) ack0++;
        if (byte_ack[1]) ack1++;
        if (txn_done[0]) done0++;
        if (txn_done[1]) done1++;
        if (rx_valid[0]) rxv0++;
        if (rx_valid[1]) rxv1++;
        if (rx_valid != 2'b00 && rxn < 32) begin rx_log[rxn] = rx_data; rxn++; end
        if (!cs_n && p_cs) begin t_cs_fall = cyc; armed = 1'b1; cs_falls++; end
        if (!spi_done && p_done) t_done_fall = cyc;
        if (cs_n && !p_cs) hold_c = cyc - t_done_fall;
        if (spi_start && !p_start) begin
            start_rises++;
            period = cyc - t_rise;
            t_rise = cyc;
            if (armed) begin setup_c = cyc - t_cs_fall; armed = 1'b0; end
        end
        if (spi_start) run++;
        else if (p_start) begin hi_last = run; run = 0; end
        if (grant != 2'b00) g_hi++;
        if (grant != 2'b00 && p_grant == 2'b00 && gn < 16) begin g_log[gn] = grant; gn++; end
        p_cs = cs_n; p_start = spi_start; p_done = spi_done; p_grant = grant;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input int maxc);
        int n = 0;
        while (grant == 2'b00 && n < maxc) begin @(negedge clk); #1; n++; end
        chk(tag, 32'(grant != 2'b00), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int r, input int target, input int maxc);
        int n = 0;
        while (((r == 0) ? done0 : done1) < target && n < maxc) begin @(negedge clk); #1; n++; end
        chk(tag, 32'(((r == 0) ? done0 : done1) >= target), 32'd1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    int s_ack0, s_rxn, s_done0, s_done1, s_gn, s_start, s_falls, s_ghi, n;

    initial begin
        for (int i = 0; i < 4; i++) begin tab0[i] = 8'h00; tab1[i] = 8'h00; end
        // Reset state, with both requesters already asking for one byte.
        req = 2'b11;
        req_len = 8'h11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_pulses", {byte_ack, rx_valid, txn_done}, 6'd0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_spi_tx", spi_tx_data, 8'h00);

        // Contention: continuous req=11 alternates starting with req0.
        s_gn = gn;
        rst_n = 1'b1;
        n = 0;
        while (gn < s_gn + 3 && n < 2000) begin @(negedge clk); #1; n++; end
        req = 2'b00;
        chk("cont_three_grants", 32'(gn >= s_gn + 3), 32'd1);
        wait_done("cont_wait", 0, 2, 500);
        chk("cont_g0", g_log[s_gn], 2'b01);
        chk("cont_g1", g_log[s_gn + 1], 2'b10);
        chk("cont_g2", g_log[s_gn + 2], 2'b01);
        chk("cont_no_extra", gn, s_gn + 3);
        chk("cont_done0", done0, 2);
        chk("cont_done1", done1, 1);

        // Single two-byte transaction from req0.
        tab0[0] = 8'hA5; tab0[1] = 8'h3C; base0 = txi0;
        req_len = 8'h02; lat = 3; hold = 1;
        s_ack0 = ack0; s_rxn = rxn; s_done0 = done0; s_done1 = done1;
        req = 2'b01;
        wait_grant("single_grant_wait", 50);
        req = 2'b00;
        chk("single_grant", grant, 2'b01);
        wait_done("single_wait", 0, s_done0 + 1, 400);
        chk("single_setup", setup_c, CSD + 1);
        chk("single_hold", hold_c, CSD + 1);
        chk("single_acks", ack0 - s_ack0, 2);
        chk("single_rx_cnt", rxn - s_rxn, 2);
        chk("single_rx0", rx_log[s_rxn], 8'hA5);
        chk("single_rx1", rx_log[s_rxn + 1], 8'h3C);
        chk("single_done0", done0 - s_done0, 1);
        chk("single_done1", done1 - s_done1, 0);
        chk("single_cs_idle", cs_n, 1'b1);

        // Zero-length request from req1: grant one cycle, no SPI activity.
        req_len = 8'h00;
        s_done1 = done1; s_start = start_rises; s_falls = cs_falls; s_ghi = g_hi;
        req = 2'b10;
        wait_grant("len0_grant_wait", 50);
        req = 2'b00;
        chk("len0_grant", grant, 2'b10);
        chk("len0_done_now", txn_done, 2'b10);
        wait_done("len0_wait", 1, s_done1 + 1, 50);
        chk("len0_done1", done1 - s_done1, 1);
        chk("len0_cs_never_low", cs_falls - s_falls, 0);
        chk("len0_no_start", start_rises - s_start, 0);
        chk("len0_grant_cycles", g_hi - s_ghi, 1);

        // Slow master: 500-cycle latency, done held 3 cycles.
        tab0[0] = 8'h5A; tab0[1] = 8'hC3; base0 = txi0;
        req_len = 8'h02; lat = 500; hold = 3;
        s_rxn = rxn; s_done0 = done0;
        req = 2'b01;
        wait_grant("slow_grant_wait", 50);
        req = 2'b00;
        wait_done("slow_wait", 0, s_done0 + 1, 3000);
        chk("slow_start_high", hi_last, 501);
        chk("slow_byte_period", period, 500 + 3 + GAPC + 2);
        chk("slow_hold", hold_c, CSD + 1);
        chk("slow_rx0", rx_log[s_rxn], 8'h5A);
        chk("slow_rx1", rx_log[s_rxn + 1], 8'hC3);

        // Reset in the middle of the first byte of a 3-byte transaction.
        tab0[0] = 8'h11; tab0[1] = 8'h22; tab0[2] = 8'h33; base0 = txi0;
        req_len = 8'h03; lat = 500; hold = 1;
        s_done0 = done0;
        req = 2'b01;
        wait_grant("rst_mid_grant_wait", 50);
        req = 2'b00;
        n = 0;
        while (!spi_start && n < 100) begin @(negedge clk); #1; n++; end
        chk("rst_mid_in_byte", spi_start, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", cs_n, 1'b1);
        chk("rst_mid_start", spi_start, 1'b0);
        chk("rst_mid_grant", grant, 2'b00);
        chk("rst_mid_rx_data", rx_data, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_mid_no_done", done0 - s_done0, 0);

        // Fresh request after the reset.
        tab1[0] = 8'h77; base1 = txi1;
        req_len = 8'h10; lat = 3; hold = 1;
        s_rxn = rxn; s_done1 = done1;
        req = 2'b10;
        wait_grant("fresh_grant_wait", 50);
        req = 2'b00;
        chk("fresh_grant", grant, 2'b10);
        wait_done("fresh_wait", 1, s_done1 + 1, 400);
        chk("fresh_rx", rx_log[s_rxn], 8'h77);

        // req0 dropped right after grant: all three bytes still go out.
        tab0[0] = 8'hDE; tab0[1] = 8'hAD; tab0[2] = 8'hBE; base0 = txi0;
        req_len = 8'h03;
        s_ack0 = ack0; s_rxn = rxn; s_done0 = done0;
        req = 2'b01;
        wait_grant("drop_grant_wait", 50);
        req = 2'b00;
        wait_done("drop_wait", 0, s_done0 + 1, 600);
        chk("drop_acks", ack0 - s_ack0, 3);
        chk("drop_rx0", rx_log[s_rxn], 8'hDE);
        chk("drop_rx1", rx_log[s_rxn + 1], 8'hAD);
        chk("drop_rx2", rx_log[s_rxn + 2], 8'hBE);
        chk("drop_done0", done0 - s_done0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
